// File: rtl/joy_serial_scanner_if.sv
// Pin and result bundle between the serial joystick scanner and its consumer.
// The scanner drives the shift-register pins and the decoded player words.
interface joy_serial_scanner_if;
   localparam int unsigned JOY_W = 12;

   logic             joy_data_i;
   logic             joy_clk_o;
   logic             joy_load_o;
   logic [JOY_W-1:0] joy1_o;
   logic [JOY_W-1:0] joy2_o;
   logic             frame_done_o;
   logic             joy_upd_o;

   modport master (
      input  joy_data_i,
      output joy_clk_o,
      output joy_load_o,
      output joy1_o,
      output joy2_o,
      output frame_done_o,
      output joy_upd_o
   );

   modport slave (
      output joy_data_i,
      input  joy_clk_o,
      input  joy_load_o,
      input  joy1_o,
      input  joy2_o,
      input  frame_done_o,
      input  joy_upd_o
   );
endinterface

// File: rtl/joy_serial_scanner.sv
// Scans an external serial joystick shift register and de-serialises each 26-slot frame
// into two double-buffered, optionally debounced, active-low 12-bit player words.
module joy_serial_scanner #(
   parameter int unsigned CLK_DIV  = 32,
   parameter int unsigned DEBOUNCE = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ena,
   joy_serial_scanner_if.master bus
);
   localparam int unsigned HALF      = CLK_DIV / 2;
   localparam int unsigned DIV_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned SLOT_W    = 5;
   localparam int unsigned LAST_SLOT = 25;
   localparam int unsigned FIRST_CAP = 2;
   localparam int unsigned JOY_W     = 12;
   localparam int unsigned FRAME_W   = 2 * JOY_W;

   logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic [SLOT_W-1:0]  slot_q, slot_d;
   logic               joy_clk_q, joy_clk_d;
   logic               joy_load_q, joy_load_d;
   logic [FRAME_W-1:0] shadow_q, shadow_d;
   logic [FRAME_W-1:0] prev_q, prev_d;
   logic [FRAME_W-1:0] joy_q, joy_d;
   logic               done_q, done_d;
   logic               upd_q, upd_d;
   logic               tick_c;

   // Shadow bit (j1 in [11:0], j2 in [23:12]) written by each capture slot.
   function automatic logic [4:0] slot_bit(input logic [SLOT_W-1:0] s);
      logic [4:0] b;
      b = 5'd0;
      case (s)
         5'd2:  b = 5'd8;   5'd3:  b = 5'd6;
         5'd4:  b = 5'd5;   5'd5:  b = 5'd4;   5'd6:  b = 5'd3;
         5'd7:  b = 5'd2;   5'd8:  b = 5'd1;   5'd9:  b = 5'd0;
         5'd10: b = 5'd20;  5'd11: b = 5'd18;
         5'd12: b = 5'd17;  5'd13: b = 5'd16;  5'd14: b = 5'd15;
         5'd15: b = 5'd14;  5'd16: b = 5'd13;  5'd17: b = 5'd12;
         5'd18: b = 5'd22;  5'd19: b = 5'd23;  5'd20: b = 5'd21;
         5'd21: b = 5'd19;  5'd22: b = 5'd10;  5'd23: b = 5'd11;
         5'd24: b = 5'd9;   5'd25: b = 5'd7;
         default: b = 5'd0;
      endcase
      return b;
   endfunction

   assign tick_c = ena && (div_cnt_q == DIV_W'(HALF - 1));

   always_comb begin
      div_cnt_d  = div_cnt_q;
      slot_d     = slot_q;
      joy_clk_d  = joy_clk_q;
      joy_load_d = joy_load_q;
      shadow_d   = shadow_q;
      prev_d     = prev_q;
      joy_d      = joy_q;
      done_d     = 1'b0;
      upd_d      = 1'b0;

      if (!ena) begin
         div_cnt_d  = '0;
         slot_d     = '0;
         joy_clk_d  = 1'b0;
         joy_load_d = 1'b1;
         shadow_d   = '1;
      end else begin
         div_cnt_d = (div_cnt_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt_q + DIV_W'(1);
         joy_clk_d = (div_cnt_d >= DIV_W'(HALF));
         if (tick_c) begin
            slot_d     = (slot_q == SLOT_W'(LAST_SLOT)) ? '0 : slot_q + SLOT_W'(1);
            joy_load_d = (slot_d != '0);
            if (slot_q >= SLOT_W'(FIRST_CAP)) begin
               shadow_d[slot_bit(slot_q)] = bus.joy_data_i;
            end
            // Last capture: commit the whole frame at once on the next cycle.
            if (slot_q == SLOT_W'(LAST_SLOT)) begin
               done_d = 1'b1;
               prev_d = shadow_d;
               if ((DEBOUNCE == 0) || (shadow_d == prev_q)) begin
                  joy_d = shadow_d;
                  upd_d = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt_q  <= '0;
         slot_q     <= '0;
         joy_clk_q  <= 1'b0;
         joy_load_q <= 1'b1;
         shadow_q   <= '1;
         prev_q     <= '1;
         joy_q      <= '1;
         done_q     <= 1'b0;
         upd_q      <= 1'b0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         slot_q     <= slot_d;
         joy_clk_q  <= joy_clk_d;
         joy_load_q <= joy_load_d;
         shadow_q   <= shadow_d;
         prev_q     <= prev_d;
         joy_q      <= joy_d;
         done_q     <= done_d;
         upd_q      <= upd_d;
      end
   end

   assign bus.joy_clk_o    = joy_clk_q;
   assign bus.joy_load_o   = joy_load_q;
   assign bus.joy1_o       = joy_q[JOY_W-1:0];
   assign bus.joy2_o       = joy_q[FRAME_W-1:JOY_W];
   assign bus.frame_done_o = done_q;
   assign bus.joy_upd_o    = upd_q;
endmodule
